// File: rtl/vector_lane_sequencer_if.sv
// ---------------------------------------------------------------------------
// vector_lane_sequencer_if
//
// Bundles every handshake and data signal of the vector lane sequencer.
//   Instruction request : req_valid, req_ready, req_opcode, req_op_1, req_op_2
//   Lane unit channel   : lane_valid, lane_op, lane_a, lane_b,
//                         lane_done, lane_result
//   Response channel    : resp_valid, resp_ready, resp_result, resp_err
//   Status              : busy
//
// Modports
//   slave  : the sequencer itself.
//   master : the surrounding environment (issue logic, lane unit, consumer).
// ---------------------------------------------------------------------------
interface vector_lane_sequencer_if #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16
);
    localparam int VEC_W = LANES * LANE_W;

    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_opcode;
    logic [VEC_W-1:0]  req_op_1;
    logic [VEC_W-1:0]  req_op_2;

    logic              lane_valid;
    logic              lane_op;
    logic [LANE_W-1:0] lane_a;
    logic [LANE_W-1:0] lane_b;
    logic              lane_done;
    logic [LANE_W-1:0] lane_result;

    logic              resp_valid;
    logic              resp_ready;
    logic [VEC_W-1:0]  resp_result;
    logic              resp_err;

    logic              busy;

    modport slave (
        input  req_valid, req_opcode, req_op_1, req_op_2,
        output req_ready,
        output lane_valid, lane_op, lane_a, lane_b,
        input  lane_done, lane_result,
        output resp_valid, resp_result, resp_err,
        input  resp_ready,
        output busy
    );

    modport master (
        output req_valid, req_opcode, req_op_1, req_op_2,
        input  req_ready,
        input  lane_valid, lane_op, lane_a, lane_b,
        output lane_done, lane_result,
        input  resp_valid, resp_result, resp_err,
        output resp_ready,
        input  busy
    );
endinterface

// File: rtl/vector_lane_sequencer.sv
// ---------------------------------------------------------------------------
// vector_lane_sequencer
//
// Executes one vector instruction (LANES x LANE_W-bit FP16 lanes) by issuing
// one scalar add/multiply at a time to a shared lane unit with variable
// latency, gathering the scalar results into a result vector.
//
// Opcodes: 0000 VADD, 0001 VDOT, 0010 SMUL, 1111 NOP, anything else illegal.
//
// Ports
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : vector_lane_sequencer_if.slave
//          req_*  instruction in (valid/ready, accepted only in IDLE)
//          lane_* one outstanding scalar operation to the lane unit
//          resp_* result vector and error flag (valid/ready)
//          busy   high whenever the sequencer is not IDLE
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module vector_lane_sequencer #(
    parameter int LANES   = 16,
    parameter int LANE_W  = 16,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    vector_lane_sequencer_if.slave bus
);

    localparam int VEC_W = LANES * LANE_W;
    localparam int IDX_W = $clog2(LANES);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LANES - 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT - 1);

    localparam logic [3:0] OP_VADD = 4'b0000;
    localparam logic [3:0] OP_VDOT = 4'b0001;
    localparam logic [3:0] OP_SMUL = 4'b0010;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_NEXT,
        S_RESP
    } state_t;

    state_t             state_q;
    logic [3:0]         opc_q;
    logic [VEC_W-1:0]   op1_q;
    logic [VEC_W-1:0]   op2_q;
    logic [IDX_W-1:0]   idx_q;
    logic               step_q;
    logic [LANE_W-1:0]  acc_q;
    logic [LANE_W-1:0]  tmp_q;
    logic [TMR_W-1:0]   tmr_q;

    logic               req_ready_q;
    logic               busy_q;
    logic               lane_valid_q;
    logic               lane_op_q;
    logic [LANE_W-1:0]  lane_a_q;
    logic [LANE_W-1:0]  lane_b_q;
    logic               resp_valid_q;
    logic               resp_err_q;
    logic [VEC_W-1:0]   resp_result_q;

    logic [IDX_W-1:0]   idx_d;
    logic               step_d;
    logic               last_op;

    // Opcodes that actually drive the lane unit.
    function automatic logic is_lane_op(input logic [3:0] opc);
        return (opc == OP_VADD) || (opc == OP_VDOT) || (opc == OP_SMUL);
    endfunction

    // Lane command {op, a, b} for operation (idx, step) of an instruction.
    // op: 0 = add, 1 = multiply.
    function automatic logic [2*LANE_W:0] lane_cmd(
        input logic [3:0]        opc,
        input logic [IDX_W-1:0]  idx,
        input logic              step,
        input logic [VEC_W-1:0]  op1,
        input logic [VEC_W-1:0]  op2,
        input logic [LANE_W-1:0] acc,
        input logic [LANE_W-1:0] tmp
    );
        logic [LANE_W-1:0] a_i;
        logic [LANE_W-1:0] b_i;
        a_i = op1[idx*LANE_W +: LANE_W];
        b_i = op2[idx*LANE_W +: LANE_W];
        case (opc)
            // SMUL broadcasts lane 0 of op_1 as the scalar.
            OP_SMUL: return {1'b1, op1[LANE_W-1:0], b_i};
            // VDOT alternates product (step 0) and accumulate (step 1).
            OP_VDOT: return step ? {1'b0, acc, tmp} : {1'b1, a_i, b_i};
            default: return {1'b0, a_i, b_i};
        endcase
    endfunction

    // Position of the following operation; only VDOT has a second step
    // per lane.
    always_comb begin
        idx_d  = idx_q;
        step_d = 1'b0;
        if ((opc_q == OP_VDOT) && !step_q) begin
            step_d = 1'b1;
        end else begin
            idx_d = idx_q + 1'b1;
        end
    end

    assign last_op = (idx_q == LAST_IDX) && ((opc_q != OP_VDOT) || step_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            opc_q         <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            idx_q         <= '0;
            step_q        <= 1'b0;
            acc_q         <= '0;
            tmp_q         <= '0;
            tmr_q         <= '0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            lane_valid_q  <= 1'b0;
            lane_op_q     <= 1'b0;
            lane_a_q      <= '0;
            lane_b_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        opc_q         <= bus.req_opcode;
                        op1_q         <= bus.req_op_1;
                        op2_q         <= bus.req_op_2;
                        idx_q         <= '0;
                        step_q        <= 1'b0;
                        acc_q         <= '0;
                        tmp_q         <= '0;
                        tmr_q         <= '0;
                        resp_result_q <= '0;
                        req_ready_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        if (is_lane_op(bus.req_opcode)) begin
                            state_q      <= S_ISSUE;
                            lane_valid_q <= 1'b1;
                            {lane_op_q, lane_a_q, lane_b_q} <= lane_cmd(
                                bus.req_opcode, '0, 1'b0,
                                bus.req_op_1, bus.req_op_2, '0, '0);
                        end else begin
                            // NOP and illegal opcodes answer at once with
                            // an all-zero result.
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= (bus.req_opcode != OP_NOP);
                        end
                    end
                end

                S_ISSUE: begin
                    if (bus.lane_done) begin
                        lane_valid_q <= 1'b0;
                        state_q      <= S_NEXT;
                        if (opc_q == OP_VDOT) begin
                            if (step_q) begin
                                acc_q <= bus.lane_result;
                            end else begin
                                tmp_q <= bus.lane_result;
                            end
                        end else begin
                            resp_result_q[idx_q*LANE_W +: LANE_W] <= bus.lane_result;
                        end
                    end else if (tmr_q == TMR_LIMIT) begin
                        // Lane unit stalled: abort with whatever has been
                        // gathered so far.
                        lane_valid_q <= 1'b0;
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        if (opc_q == OP_VDOT) begin
                            resp_result_q <= VEC_W'(acc_q);
                        end
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end

                S_NEXT: begin
                    if (last_op) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        if (opc_q == OP_VDOT) begin
                            resp_result_q <= VEC_W'(acc_q);
                        end
                    end else begin
                        // acc/tmp were updated on the ISSUE exit edge, so
                        // the step-1 operands are already current here.
                        state_q      <= S_ISSUE;
                        idx_q        <= idx_d;
                        step_q       <= step_d;
                        tmr_q        <= '0;
                        lane_valid_q <= 1'b1;
                        {lane_op_q, lane_a_q, lane_b_q} <= lane_cmd(
                            opc_q, idx_d, step_d, op1_q, op2_q, acc_q, tmp_q);
                    end
                end

                S_RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.busy        = busy_q;
    assign bus.lane_valid  = lane_valid_q;
    assign bus.lane_op     = lane_op_q;
    assign bus.lane_a      = lane_a_q;
    assign bus.lane_b      = lane_b_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.resp_result = resp_result_q;

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vector_lane_sequencer
//
// Directed bench for vector_lane_sequencer. A single process drives the
// instruction/response side, plays the lane unit and compares the DUT each
// negative clock edge against an operation list and result vector built
// from the instruction semantics.
// ---------------------------------------------------------------------------
module tb_vector_lane_sequencer;

    localparam int LANES   = 16;
    localparam int LANE_W  = 16;
    localparam int TIMEOUT = 255;

    localparam logic [3:0] VADD = 4'b0000;
    localparam logic [3:0] VDOT = 4'b0001;
    localparam logic [3:0] SMUL = 4'b0010;
    localparam logic [3:0] NOP  = 4'b1111;
    localparam logic [3:0] ILL  = 4'b0101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vector_lane_sequencer_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

    vector_lane_sequencer #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    int cyc, nops, gap, prev_lv, issue_cnt, resp_cyc;
    int lat, lmode, hang_op, noise;
    logic [32:0]  exp_ops[$];
    logic [255:0] exp_res;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // FP16 helpers for positive values only (enough for the dot product).
    function automatic real h2r(input logic [15:0] h);
        real r;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) begin
            r = real'(h[9:0]) / 16777216.0;
        end else begin
            r = 1.0 + real'(h[9:0]) / 1024.0;
            for (int k = 0; k < e - 15; k++) r = r * 2.0;
            for (int k = 0; k < 15 - e; k++) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        int          e;
        int          m;
        real         x;
        logic [4:0]  ev;
        logic [9:0]  mv;
        if (r <= 0.0) return 16'h0000;
        x = r;
        e = 15;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0)  begin x = x * 2.0; e--; end
        m  = int'((x - 1.0) * 1024.0);
        ev = e[4:0];
        mv = m[9:0];
        return {1'b0, ev, mv};
    endfunction

    // Lane unit behaviour: 0 = constant 3.0, 1 = echo b, 2 = real FP16.
    function automatic logic [15:0] lane_fn(input int mode, input logic op,
                                            input logic [15:0] a, input logic [15:0] b);
        case (mode)
            0:       return 16'h4200;
            1:       return b;
            default: return op ? r2h(h2r(a) * h2r(b)) : r2h(h2r(a) + h2r(b));
        endcase
    endfunction

    // Expected operation sequence and final vector, from instruction semantics.
    // hang >= 0 marks the op that never completes (VADD/SMUL only).
    task automatic build(input logic [3:0] opc, input logic [255:0] a,
                         input logic [255:0] b, input int hang);
        int          nl;
        logic [15:0] ai, bi, t, acc;
        exp_ops.delete();
        exp_res = '0;
        acc     = 16'h0000;
        nl      = (hang < 0) ? LANES : hang + 1;
        for (int i = 0; i < nl; i++) begin
            ai = a[16*i +: 16];
            bi = b[16*i +: 16];
            case (opc)
                VADD: begin
                    exp_ops.push_back({1'b0, ai, bi});
                    if (i != hang) exp_res[16*i +: 16] = lane_fn(lmode, 1'b0, ai, bi);
                end
                SMUL: begin
                    exp_ops.push_back({1'b1, a[15:0], bi});
                    if (i != hang) exp_res[16*i +: 16] = lane_fn(lmode, 1'b1, a[15:0], bi);
                end
                VDOT: begin
                    t = lane_fn(lmode, 1'b1, ai, bi);
                    exp_ops.push_back({1'b1, ai, bi});
                    exp_ops.push_back({1'b0, acc, t});
                    acc = lane_fn(lmode, 1'b0, acc, t);
                    exp_res = {240'b0, acc};
                end
                default: ;
            endcase
        end
    endtask

    // One clock: compare DUT outputs, then play the lane unit.
    task automatic tick();
        logic [32:0] e;
        @(negedge clk);
        cyc++;
        chk("ready_vs_busy", bus.req_ready, !bus.busy);
        if (bus.lane_valid) begin
            if (prev_lv == 0) begin
                nops++;
                issue_cnt = 0;
                if (nops > 1) chk("gap_one_cycle", gap, 1);
            end
            issue_cnt++;
            gap = 0;
            if (nops <= exp_ops.size()) begin
                e = exp_ops[nops-1];
                chk("lane_op", bus.lane_op, e[32]);
                chk("lane_a", bus.lane_a, e[31:16]);
                chk("lane_b", bus.lane_b, e[15:0]);
            end else begin
                checks++;
                errors++;
                $display("FAIL extra_lane_op: op %0d issued, only %0d required", nops, exp_ops.size());
            end
            bus.lane_done   = (issue_cnt >= lat) && (nops - 1 != hang_op);
            bus.lane_result = lane_fn(lmode, bus.lane_op, bus.lane_a, bus.lane_b);
        end else begin
            gap++;
            bus.lane_done   = (noise != 0);
            bus.lane_result = 16'hDEAD;
        end
        if (bus.resp_valid && resp_cyc < 0) resp_cyc = cyc;
        prev_lv = bus.lane_valid;
    endtask

    task automatic start(input logic [3:0] opc, input logic [255:0] a, input logic [255:0] b);
        bus.req_valid  = 1'b1;
        bus.req_opcode = opc;
        bus.req_op_1   = a;
        bus.req_op_2   = b;
        cyc = 0; nops = 0; gap = 0; prev_lv = 0; issue_cnt = 0; resp_cyc = -1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic run(input string nm, input logic [3:0] opc, input logic [255:0] a,
                       input logic [255:0] b, input int lat_i, input int mode_i,
                       input int hang_i, input int noise_i, input int exp_cyc,
                       input logic exp_err, input int hold);
        int n;
        lat = lat_i; lmode = mode_i; hang_op = hang_i; noise = noise_i;
        build(opc, a, b, hang_i);
        chk({nm, "_ready_in_idle"}, bus.req_ready, 1'b1);
        start(opc, a, b);
        n = 0;
        while (!bus.resp_valid && n < 600) begin
            tick();
            n++;
        end
        chk({nm, "_resp_cycle"}, resp_cyc, exp_cyc);
        chk({nm, "_op_count"}, nops, exp_ops.size());
        chk({nm, "_result"}, bus.resp_result, exp_res);
        chk({nm, "_err"}, bus.resp_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            bus.req_valid  = 1'b1;
            bus.req_opcode = VADD;
            tick();
            chk({nm, "_hold_valid"}, bus.resp_valid, 1'b1);
            chk({nm, "_hold_result"}, bus.resp_result, exp_res);
            chk({nm, "_hold_err"}, bus.resp_err, exp_err);
            chk({nm, "_hold_not_ready"}, bus.req_ready, 1'b0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk({nm, "_resp_drop"}, bus.resp_valid, 1'b0);
        chk({nm, "_back_idle"}, bus.req_ready, 1'b1);
        if (hold > 0) begin
            tick();
            chk({nm, "_stays_idle"}, bus.busy, 1'b0);
        end
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_req_ready"}, bus.req_ready, 1'b1);
        chk({nm, "_busy"}, bus.busy, 1'b0);
        chk({nm, "_lane_valid"}, bus.lane_valid, 1'b0);
        chk({nm, "_lane_op"}, bus.lane_op, 1'b0);
        chk({nm, "_lane_a"}, bus.lane_a, 16'h0);
        chk({nm, "_lane_b"}, bus.lane_b, 16'h0);
        chk({nm, "_resp_valid"}, bus.resp_valid, 1'b0);
        chk({nm, "_resp_err"}, bus.resp_err, 1'b0);
        chk({nm, "_resp_result"}, bus.resp_result, 256'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [255:0] a, b;
        int n;
        bus.req_valid = 1'b0; bus.req_opcode = 4'h0; bus.req_op_1 = '0; bus.req_op_2 = '0;
        bus.resp_ready = 1'b0; bus.lane_done = 1'b0; bus.lane_result = 16'h0;
        lat = 1; lmode = 0; hang_op = -1; noise = 0;
        cyc = 0; nops = 0; gap = 0; prev_lv = 0; issue_cnt = 0; resp_cyc = -1;

        // Pin the FP16 model with hand-computed values.
        chk("model_add_1_1", lane_fn(2, 1'b0, 16'h3C00, 16'h3C00), 16'h4000);
        chk("model_mul_2_2", lane_fn(2, 1'b1, 16'h4000, 16'h4000), 16'h4400);
        chk("model_add_15_1", lane_fn(2, 1'b0, 16'h4B80, 16'h3C00), 16'h4C00);

        tick(); tick();
        check_reset("por");
        rst = 1'b0;
        tick();

        // VADD, zero latency, constant-3.0 lane unit.
        for (int i = 0; i < LANES; i++) begin a[16*i +: 16] = 16'h3C00; b[16*i +: 16] = 16'h4000; end
        run("vadd", VADD, a, b, 1, 0, -1, 0, 33, 1'b0, 0);

        // SMUL, three-cycle lane unit that echoes b.
        for (int i = 0; i < LANES; i++) begin a[16*i +: 16] = 16'h1000 + 16'(i); b[16*i +: 16] = 16'(i); end
        a[15:0] = 16'h4000;
        lmode = 1;
        build(SMUL, a, b, -1);
        chk("model_smul_lane9", exp_res[16*9 +: 16], 16'h0009);
        run("smul", SMUL, a, b, 3, 1, -1, 0, 65, 1'b0, 0);

        // VDOT of all-ones vectors with a real FP16 lane unit.
        for (int i = 0; i < LANES; i++) begin a[16*i +: 16] = 16'h3C00; b[16*i +: 16] = 16'h3C00; end
        lmode = 2;
        build(VDOT, a, b, -1);
        chk("model_vdot_result", exp_res, {240'b0, 16'h4C00});
        chk("model_vdot_ops", exp_ops.size(), 32);
        run("vdot", VDOT, a, b, 1, 2, -1, 0, 65, 1'b0, 0);

        // Illegal opcode and NOP: immediate response, zero result.
        for (int i = 0; i < LANES; i++) begin a[16*i +: 16] = 16'hABCD; b[16*i +: 16] = 16'h1234; end
        run("illegal", ILL, a, b, 1, 0, -1, 0, 1, 1'b1, 0);
        run("nop", NOP, a, b, 1, 0, -1, 0, 1, 1'b0, 0);

        // Timeout on lane 3 of a VADD; stray lane_done outside ISSUE.
        for (int i = 0; i < LANES; i++) begin a[16*i +: 16] = 16'h0100 + 16'(i); b[16*i +: 16] = 16'h2000 + 16'(i); end
        run("timeout", VADD, a, b, 1, 1, 3, 1, 7 + TIMEOUT, 1'b1, 0);
        noise = 0;

        // Asynchronous reset while lane 7 of a VADD is in flight.
        lat = 1; lmode = 0; hang_op = -1; noise = 0;
        for (int i = 0; i < LANES; i++) begin a[16*i +: 16] = 16'h3C00; b[16*i +: 16] = 16'h4000; end
        build(VADD, a, b, -1);
        start(VADD, a, b);
        n = 0;
        while (!(nops == 8 && bus.lane_valid) && n < 100) begin
            tick();
            n++;
        end
        chk("reached_lane7", nops, 8);
        #2 rst = 1'b1;
        #1 check_reset("midrst");
        tick();
        check_reset("midrst_held");
        rst = 1'b0;
        tick();

        // Fresh VADD after reset, 2-cycle lane unit, response held off.
        for (int i = 0; i < LANES; i++) begin
            a[16*i +: 16] = 16'h3C00;
            b[16*i +: 16] = (i % 2 == 0) ? 16'h3C00 : 16'h4000;
        end
        run("post_rst", VADD, a, b, 2, 2, -1, 0, 49, 1'b0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
